brick_field: RTL and testbench

- Downstream consumer of the ball physics block's brick-hit outputs (erase_enable, e_pos, active_data).
- Keeps the authoritative per-brick damage level for the 10-brick field (2 rows × 5).
- Renders bricks into the VGA pixel stream through a 2-stage pipeline, with a white hit-flash on the most recently struck brick.
- Reports remaining-brick count and an all-clear flag to game control.

---
 rtl/breakout_pkg.sv | 36 +++
 rtl/brick_field_if.sv | 23 ++
 rtl/brick_field_locator.sv | 39 +++
 rtl/brick_field.sv | 112 +++++++++++
 tb/tb_brick_field.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/breakout_pkg.sv
// Shared breakout constants: screen/brick geometry, damage levels and brick colours.
// Consumed by both the ball physics block and the brick field renderer.
package breakout_pkg;

  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int BALL_SIZE       = 8;
  localparam int FIRST_ROW_Y     = 40;
  localparam int SECOND_ROW_Y    = 90;
  localparam int BLOCK_WIDTH     = 80;
  localparam int BLOCK_HEIGHT    = 30;
  localparam int BLOCK_SPACING_X = 40;
  localparam int NUM_BRICKS      = 10;
  localparam int NUM_COLS        = 5;
  localparam int BRICK_PITCH_X   = BLOCK_WIDTH + BLOCK_SPACING_X;

  typedef logic [1:0] level_t;

  localparam level_t DESTROYED_LEVEL = 2'd3;

  localparam logic [7:0] COLOR_BLANK  = 8'h00;
  localparam logic [7:0] COLOR_RED    = 8'hE0;
  localparam logic [7:0] COLOR_ORANGE = 8'hEC;
  localparam logic [7:0] COLOR_YELLOW = 8'hFC;
  localparam logic [7:0] COLOR_FLASH  = 8'hFF;

  function automatic logic [7:0] level_colour(input level_t lvl);
    case (lvl)
      2'd0:    level_colour = COLOR_RED;
      2'd1:    level_colour = COLOR_ORANGE;
      2'd2:    level_colour = COLOR_YELLOW;
      default: level_colour = COLOR_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/brick_field_if.sv
// Bundle of brick-hit strobes, VGA pixel coordinates and the field's rendered/status outputs.
interface brick_field_if;
  logic       erase_enable;
  logic [5:0] e_pos;
  logic [1:0] active_data;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic [7:0] rgb_out;
  logic       brick_px;
  logic [3:0] bricks_left;
  logic       all_clear;

  modport master (
    output erase_enable, e_pos, active_data, pixel_x, pixel_y, video_on,
    input  rgb_out, brick_px, bricks_left, all_clear
  );

  modport slave (
    input  erase_enable, e_pos, active_data, pixel_x, pixel_y, video_on,
    output rgb_out, brick_px, bricks_left, all_clear
  );
endinterface

// File: rtl/brick_field_locator.sv
// Combinational pixel-to-brick lookup: flags whether (x,y) lies inside a brick and which one.
module brick_locator
  import breakout_pkg::*;
(
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_inside,
  output logic [3:0] o_index
);

  logic       w_row_ok;
  logic       w_row;
  logic       w_col_ok;
  logic [2:0] w_col;

  always_comb begin
    w_row_ok = 1'b0;
    w_row    = 1'b0;
    w_col_ok = 1'b0;
    w_col    = 3'd0;
    if (i_y >= 10'(FIRST_ROW_Y) && i_y < 10'(FIRST_ROW_Y + BLOCK_HEIGHT)) begin
      w_row_ok = 1'b1;
    end else if (i_y >= 10'(SECOND_ROW_Y) && i_y < 10'(SECOND_ROW_Y + BLOCK_HEIGHT)) begin
      w_row_ok = 1'b1;
      w_row    = 1'b1;
    end
    // Columns start one spacing in from the left edge, so brick c begins at SPACING + c*PITCH
    for (int c = 0; c < NUM_COLS; c++) begin
      if (i_x >= 10'(BLOCK_SPACING_X + BRICK_PITCH_X * c) &&
          i_x <  10'(BLOCK_SPACING_X + BRICK_PITCH_X * c + BLOCK_WIDTH)) begin
        w_col_ok = 1'b1;
        w_col    = 3'(c);
      end
    end
    o_inside = w_row_ok && w_col_ok;
    o_index  = o_inside ? (4'(w_col) + (w_row ? 4'(NUM_COLS) : 4'd0)) : 4'd0;
  end

endmodule

// File: rtl/brick_field.sv
// Brick damage store, hit-flash timer, 2-stage brick renderer and remaining-brick status.
module brick_field
  import breakout_pkg::*;
#(
  parameter int FLASH_CYCLES = 2500000,
  parameter int FLASH_W      = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          game_reset,
  brick_field_if.slave  bus
);

  logic [NUM_BRICKS-1:0][1:0] r_lvl;
  logic [FLASH_W-1:0]         r_flash_tmr;
  logic [3:0]                 r_flash_idx;
  logic                       w_hit;
  logic                       w_inside;
  logic [3:0]                 w_index;

  logic       r_vld_p1;
  logic       r_inside_p1;
  logic [3:0] r_idx_p1;
  level_t     w_lvl_p1;
  logic       w_flash_p1;
  logic [7:0] r_rgb_p2;
  logic       r_px_p2;

  logic [3:0] w_left;
  logic [3:0] r_left;
  logic       r_clear;

  assign w_hit = bus.erase_enable && (bus.e_pos < 6'(NUM_BRICKS));

  brick_locator u_locator (
    .i_x      (bus.pixel_x),
    .i_y      (bus.pixel_y),
    .o_inside (w_inside),
    .o_index  (w_index)
  );

  // game_reset outranks a coincident hit so a restart always yields a clean field
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lvl       <= '0;
      r_flash_tmr <= '0;
      r_flash_idx <= '0;
    end else if (game_reset) begin
      r_lvl       <= '0;
      r_flash_tmr <= '0;
    end else if (w_hit) begin
      r_lvl[bus.e_pos[3:0]] <= bus.active_data;
      r_flash_idx           <= bus.e_pos[3:0];
      r_flash_tmr           <= FLASH_W'(FLASH_CYCLES);
    end else if (r_flash_tmr != '0) begin
      r_flash_tmr <= r_flash_tmr - 1'b1;
    end
  end

  // Stage 1: register video_on and the brick lookup for the sampled pixel
  always_ff @(posedge clk) begin
    if (!reset) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= bus.video_on;
  end

  always_ff @(posedge clk) begin
    r_inside_p1 <= w_inside;
    r_idx_p1    <= w_index;
  end

  // Stage 2: colour from the level as stored before any same-cycle write
  always_comb begin
    w_lvl_p1   = (r_idx_p1 < 4'(NUM_BRICKS)) ? r_lvl[r_idx_p1] : DESTROYED_LEVEL;
    w_flash_p1 = (r_flash_tmr != '0) && (r_idx_p1 == r_flash_idx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rgb_p2 <= COLOR_BLANK;
      r_px_p2  <= 1'b0;
    end else if (!r_vld_p1 || !r_inside_p1 || w_lvl_p1 == DESTROYED_LEVEL) begin
      r_rgb_p2 <= COLOR_BLANK;
      r_px_p2  <= 1'b0;
    end else begin
      r_rgb_p2 <= w_flash_p1 ? COLOR_FLASH : level_colour(w_lvl_p1);
      r_px_p2  <= 1'b1;
    end
  end

  always_comb begin
    w_left = 4'd0;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      if (r_lvl[i] != DESTROYED_LEVEL) w_left = w_left + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_left  <= 4'(NUM_BRICKS);
      r_clear <= 1'b0;
    end else begin
      r_left  <= w_left;
      r_clear <= (w_left == 4'd0);
    end
  end

  assign bus.rgb_out     = r_rgb_p2;
  assign bus.brick_px    = r_px_p2;
  assign bus.bricks_left = r_left;
  assign bus.all_clear   = r_clear;

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: geometric/rule-based reference model plus hand-computed spot checks.
module tb_brick_field;

  localparam int FLASH = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic game_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  brick_field_if bus ();

  brick_field #(.FLASH_CYCLES(FLASH), .FLASH_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .game_reset (game_reset),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: brick geometry by arithmetic, state as plain arrays
  int  m_lvl [10];
  int  m_ft, m_fidx;
  bit  m_on = 1'b0;
  bit  p_vld, p_in;
  int  p_idx;
  int  exp_rgb, exp_px, exp_left, exp_clear;

  function automatic void locate(input int x, input int y, output bit in, output int idx);
    int row;
    row = (y >= 40 && y < 70) ? 0 : (y >= 90 && y < 120) ? 1 : -1;
    in  = 1'b0;
    idx = 0;
    if (row >= 0 && x >= 40 && ((x - 40) % 120) < 80 && ((x - 40) / 120) < 5) begin
      in  = 1'b1;
      idx = (x - 40) / 120 + 5 * row;
    end
  endfunction

  always @(posedge clk) begin
    int cnt;
    cnt = 0;
    foreach (m_lvl[i]) if (m_lvl[i] != 3) cnt++;
    if (!reset) begin
      exp_rgb = 0; exp_px = 0; exp_left = 10; exp_clear = 0;
      p_vld = 1'b0;
      foreach (m_lvl[i]) m_lvl[i] = 0;
      m_ft = 0; m_fidx = 0;
      m_on = 1'b1;
    end else begin
      if (!p_vld || !p_in || m_lvl[p_idx] == 3) begin
        exp_rgb = 0; exp_px = 0;
      end else if (m_ft != 0 && p_idx == m_fidx) begin
        exp_rgb = 'hFF; exp_px = 1;
      end else begin
        exp_rgb = (m_lvl[p_idx] == 0) ? 'hE0 : (m_lvl[p_idx] == 1) ? 'hEC : 'hFC;
        exp_px = 1;
      end
      exp_left  = cnt;
      exp_clear = (cnt == 0);
      if (game_reset) begin
        foreach (m_lvl[i]) m_lvl[i] = 0;
        m_ft = 0;
      end else if (bus.erase_enable && bus.e_pos < 10) begin
        m_lvl[bus.e_pos] = bus.active_data;
        m_fidx = bus.e_pos;
        m_ft = FLASH;
      end else if (m_ft > 0) begin
        m_ft--;
      end
      p_vld = bus.video_on;
    end
    locate(bus.pixel_x, bus.pixel_y, p_in, p_idx);
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("model_rgb", bus.rgb_out, exp_rgb);
      chk("model_px", bus.brick_px, exp_px);
      chk("model_left", bus.bricks_left, exp_left);
      chk("model_clear", bus.all_clear, exp_clear);
    end
  end

  task automatic setpix(input int x, input int y, input bit von);
    @(negedge clk);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = von;
  endtask

  task automatic hit(input int pos, input int dat);
    @(negedge clk);
    bus.erase_enable = 1'b1;
    bus.e_pos        = 6'(pos);
    bus.active_data  = 2'(dat);
    @(negedge clk);
    bus.erase_enable = 1'b0;
  endtask

  task automatic pix_expect(input string nm, input int x, input int y, input int rgb, input int px);
    setpix(x, y, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_rgb"}, bus.rgb_out, rgb);
    chk({nm, "_px"}, bus.brick_px, px);
  endtask

  initial begin
    int ff;
    int zeros;
    logic [7:0] last;
    bus.erase_enable = 1'b0;
    bus.e_pos        = '0;
    bus.active_data  = '0;
    bus.pixel_x      = 10'd45;
    bus.pixel_y      = 10'd45;
    bus.video_on     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", bus.rgb_out, 8'h00);
    chk("reset_left", bus.bricks_left, 4'd10);
    chk("reset_clear", bus.all_clear, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    pix_expect("b0", 45, 45, 'hE0, 1);
    pix_expect("left_gap", 30, 45, 'h00, 0);
    pix_expect("row_gap", 45, 75, 'h00, 0);
    pix_expect("col_edge", 120, 45, 'h00, 0);
    pix_expect("b0_corner", 119, 69, 'hE0, 1);
    pix_expect("b6", 165, 95, 'hE0, 1);

    setpix(45, 45, 1'b1);
    hit(0, 1);
    ff = 0;
    last = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.rgb_out == 8'hFF) ff++;
      last = bus.rgb_out;
    end
    chk("flash_len", ff, FLASH);
    chk("after_flash", last, 8'hEC);
    chk("left_lvl1", bus.bricks_left, 4'd10);

    pix_expect("b9_pre", 525, 95, 'hE0, 1);
    hit(9, 3);
    @(posedge clk);
    #1;
    chk("b9_gone", bus.rgb_out, 8'h00);
    chk("left_9", bus.bricks_left, 4'd9);
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.rgb_out == 8'h00) zeros++;
    end
    chk("b9_stays_gone", zeros, 8);

    hit(10, 3);
    repeat (6) @(posedge clk);
    pix_expect("ignored_hit", 45, 45, 'hEC, 1);
    chk("left_ignored", bus.bricks_left, 4'd9);

    for (int i = 0; i < 10; i++) hit(i, 3);
    repeat (2) @(posedge clk);
    #1;
    chk("all_clear", bus.all_clear, 1'b1);
    chk("left_0", bus.bricks_left, 4'd0);

    @(negedge clk);
    game_reset       = 1'b1;
    bus.erase_enable = 1'b1;
    bus.e_pos        = 6'd2;
    bus.active_data  = 2'd2;
    bus.pixel_x      = 10'd285;
    bus.pixel_y      = 10'd45;
    @(negedge clk);
    game_reset       = 1'b0;
    bus.erase_enable = 1'b0;
    @(posedge clk);
    #1;
    chk("gr_left", bus.bricks_left, 4'd10);
    chk("gr_clear", bus.all_clear, 1'b0);
    @(posedge clk);
    #1;
    chk("gr_b2", bus.rgb_out, 8'hE0);

    hit(2, 1);
    @(posedge clk);
    #1;
    chk("b2_flash", bus.rgb_out, 8'hFF);
    @(negedge clk);
    reset        = 1'b0;
    bus.video_on = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rgb", bus.rgb_out, 8'h00);
    chk("rst_px", bus.brick_px, 1'b0);
    @(negedge clk);
    reset        = 1'b1;
    bus.video_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b2_red", bus.rgb_out, 8'hE0);
    chk("rst_left", bus.bricks_left, 4'd10);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
